// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
// The state encoding and the default 50 MHz timing values live here.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

  localparam int HOLD_50MHZ_21MS = 1048575;
  localparam int GAP_50MHZ_20US  = 1024;
  localparam int RETRIG_W        = 8;

endpackage

// File: rtl/reset_sequencer_change_detect.sv
// Flags a configuration change: loader done while the data word differs from
// the value captured on the previous edge. Suppressed on the first edge after reset.
module change_detect #(
  parameter int DATA_W = 720
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] data,
  output logic              changed
);

  logic [DATA_W-1:0] shadow;
  logic              primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      primed <= 1'b0;
    end else begin
      shadow <= data;
      primed <= 1'b1;
    end
  end

  assign changed = primed & done & (data != shadow);

endmodule

// File: rtl/reset_sequencer.sv
// Holds downstream blocks in reset, then releases N_STAGE reset outputs in order
// with a fixed gap; restarts on a configuration change or a forced retrigger.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int DATA_W      = 720,
  parameter int HOLD_CYCLES = HOLD_50MHZ_21MS,
  parameter int STAGE_GAP   = GAP_50MHZ_20US,
  parameter int N_STAGE     = 3,
  parameter int CNT_W       = 20
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iDONE,
  input  logic [DATA_W-1:0]   iDATA,
  input  logic                iFORCE,
  output logic [N_STAGE-1:0]  oRESET,
  output logic                oBUSY,
  output logic [RETRIG_W-1:0] oRETRIG_CNT
);

  localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGE - 1);

  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGE-1:0]  rel_q, rel_d;
  logic                busy_q, busy_d;
  logic [RETRIG_W-1:0] retrig_cnt_q, retrig_cnt_d;
  logic                changed;
  logic                retrig;

  change_detect #(.DATA_W(DATA_W)) u_change_detect (
    .clk     (iCLK),
    .rst     (iRST),
    .done    (iDONE),
    .data    (iDATA),
    .changed (changed)
  );

  assign retrig = changed | iFORCE;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rel_q        <= '0;
      busy_q       <= 1'b1;
      retrig_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rel_q        <= rel_d;
      busy_q       <= busy_d;
      retrig_cnt_q <= retrig_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rel_d        = rel_q;
    retrig_cnt_d = retrig_cnt_q;

    if (retrig) begin
      // Retrigger takes priority over any terminal count on the same edge.
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
      if (retrig_cnt_q != {RETRIG_W{1'b1}}) retrig_cnt_d = retrig_cnt_q + RETRIG_W'(1);
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rel_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            state_d  = (N_STAGE > 1) ? ST_STAGE : ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STAGE: begin
          if (cnt_q == GAP_LAST) begin
            rel_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          rel_d = '1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rel_d   = '0;
        end
      endcase
    end

    busy_d = ~&rel_d;
  end

  assign oRESET      = rel_q;
  assign oBUSY       = busy_q;
  assign oRETRIG_CNT = retrig_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table, async-reset
// corner case and randomized traffic against an edge-count reference model.
module tb_reset_sequencer;

  localparam int DW   = 8;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int NS   = 3;
  localparam int CW   = 5;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iDONE;
  logic [DW-1:0] iDATA;
  logic          iFORCE;
  logic [NS-1:0] oRESET;
  logic          oBUSY;
  logic [7:0]    oRETRIG_CNT;

  reset_sequencer #(
    .DATA_W(DW), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .N_STAGE(NS), .CNT_W(CW)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDONE       (iDONE),
    .iDATA       (iDATA),
    .iFORCE      (iFORCE),
    .oRESET      (oRESET),
    .oBUSY       (oBUSY),
    .oRETRIG_CNT (oRETRIG_CNT)
  );

  always #5 iCLK = ~iCLK;

  int n_tests  = 0;
  int n_failed = 0;

  // Reference model: edges since the current sequence started, plus the
  // information needed to decide whether an edge is a retrigger.
  int            m_s;
  int            m_edges;
  logic [DW-1:0] m_prev;
  int            m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] m_reset();
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = (m_s >= HOLD + k * GAP);
    return r;
  endfunction

  task automatic model_rst();
    m_s     = 0;
    m_edges = 0;
    m_prev  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic d, input logic [DW-1:0] data, input logic frc);
    logic rt;
    rt = ((m_edges >= 1) && d && (data != m_prev)) || frc;
    m_prev = data;
    m_edges++;
    if (rt) begin
      m_s = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_s < 10000) begin
      m_s++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".reset"}, int'(oRESET), int'(m_reset()));
    check({tag, ".busy"}, int'(oBUSY), int'(m_reset() != {NS{1'b1}}));
    check({tag, ".retrig_cnt"}, int'(oRETRIG_CNT), m_cnt);
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cycle(input logic d, input logic [DW-1:0] data, input logic frc);
    iDONE  = d;
    iDATA  = data;
    iFORCE = frc;
    @(posedge iCLK);
    model_edge(d, data, frc);
    @(negedge iCLK);
    check_model("cyc");
  endtask

  task automatic pulse_reset();
    iRST = 1'b1;
    model_rst();
    #1;
    check("rst.reset", int'(oRESET), 0);
    check("rst.busy", int'(oBUSY), 1);
    check("rst.retrig_cnt", int'(oRETRIG_CNT), 0);
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  typedef struct {
    logic          done;
    logic [DW-1:0] data;
    logic          frc;
    int            reps;
    logic [NS-1:0] exp_reset;
    logic          exp_busy;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic d, input logic [DW-1:0] data, input logic frc,
                              input int reps, input logic [NS-1:0] er, input logic eb,
                              input int ec);
    vec_t v;
    v.done = d; v.data = data; v.frc = frc; v.reps = reps;
    v.exp_reset = er; v.exp_busy = eb; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] cur;

    iRST = 1'b1; iDONE = 1'b0; iDATA = '0; iFORCE = 1'b0;
    model_rst();

    // Power-on sequence, data-change retrigger, no-change stability,
    // force on terminal count, and a long held force.
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,  15, 3'b000, 1'b1,   0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,   1, 3'b001, 1'b1,   0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,   3, 3'b001, 1'b1,   0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,   1, 3'b011, 1'b1,   0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,   3, 3'b011, 1'b1,   0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0,   1, 3'b111, 1'b0,   0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 100, 3'b111, 1'b0,   0));
    vecs.push_back(mk(1'b1, 8'h5A, 1'b0,   1, 3'b000, 1'b1,   1));
    vecs.push_back(mk(1'b1, 8'h5A, 1'b0,  23, 3'b011, 1'b1,   1));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,   1, 3'b111, 1'b0,   1));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b1,   1, 3'b000, 1'b1,   2));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,  15, 3'b000, 1'b1,   2));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b1,   1, 3'b000, 1'b1,   3));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,  15, 3'b000, 1'b1,   3));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,   1, 3'b001, 1'b1,   3));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b1, 300, 3'b000, 1'b1, 255));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,  23, 3'b011, 1'b1, 255));
    vecs.push_back(mk(1'b0, 8'h5A, 1'b0,   1, 3'b111, 1'b0, 255));

    @(negedge iCLK);
    check("por.reset", int'(oRESET), 0);
    check("por.busy", int'(oBUSY), 1);
    check("por.retrig_cnt", int'(oRETRIG_CNT), 0);
    iRST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].reps) cycle(vecs[i].done, vecs[i].data, vecs[i].frc);
      check($sformatf("vec%0d.reset", i), int'(oRESET), int'(vecs[i].exp_reset));
      check($sformatf("vec%0d.busy", i), int'(oBUSY), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d.retrig_cnt", i), int'(oRETRIG_CNT), vecs[i].exp_cnt);
    end

    // Asynchronous reset in the middle of STAGE, then first-edge suppression.
    pulse_reset();
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    check("mid.pre_reset", int'(oRESET), 3);
    #2;
    pulse_reset();
    cycle(1'b1, 8'h77, 1'b0);
    check("first_edge.retrig_cnt", int'(oRETRIG_CNT), 0);
    check("first_edge.reset", int'(oRESET), 0);
    repeat (5) cycle(1'b1, 8'h77, 1'b0);
    check("stable.retrig_cnt", int'(oRETRIG_CNT), 0);
    cycle(1'b1, 8'h78, 1'b0);
    check("change.retrig_cnt", int'(oRETRIG_CNT), 1);
    check("change.busy", int'(oBUSY), 1);

    // Randomized traffic against the model.
    cur = 8'h78;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 600 == 0) begin
        pulse_reset();
      end else begin
        if ($urandom % 24 == 0) cur = DW'($urandom);
        cycle(1'($urandom % 2), cur, ($urandom % 80) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
